// File: rtl/rng_seq_pkg.sv
// Shared types, constants and helpers for the RNG run sequencer.
package rng_seq_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ABORT = 2'd3
    } seq_state_e;

    function automatic logic [5:0] popcount32(input logic [WORD_W-1:0] word);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + 6'(word[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rng_run_sequencer_if.sv
// AXI-Stream output bundle of the RNG run sequencer.
interface rng_run_sequencer_if;

    logic [rng_seq_pkg::WORD_W-1:0] tdata;
    logic                           tlast;
    logic                           tvalid;
    logic                           tready;

    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);

endinterface

// File: rtl/rng_word_fifo.sv
// Synchronous word FIFO with full/empty flags and a synchronous flush.
module rng_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rng_run_sequencer.sv
// Runs one entropy collection: sampler -> word FIFO -> AXIS packets, with status back to the registers.
// Optional macro RNG_ONES_EN enables the saturating ones-count statistic on RNG_STATS.
module rng_run_sequencer
    import rng_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RNG_GO,
    input  logic                      RNG_STOP,
    input  logic [CNT_W-1:0]          RNG_SEND_BYTES,
    input  logic [CNT_W-1:0]          RNG_DMA_BYTES,
    output logic                      RNG_RUN,
    output logic                      RNG_OVER,
    output logic [CNT_W-1:0]          RNG_SENT_BYTES,
    output logic [31:0]               RNG_STATS,
    output logic                      SRC_EN,
    input  logic [WORD_W-1:0]         SRC_DATA,
    input  logic                      SRC_VALID,
    rng_run_sequencer_if.master       AXIS_RNG
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_ABORT = ST_ABORT;

    logic [1:0]        state;
    logic [CNT_W-1:0]  send_w;
    logic [CNT_W-1:0]  pkt_w;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  beat_cnt;
    logic              out_valid;
    logic              out_last;
    logic [WORD_W-1:0] out_data;
    logic              over;
    logic [CNT_W-1:0]  sent;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;

    logic              in_run;
    logic              active;
    logic              handshake;
    logic              go_start;
    logic              abort_req;
    logic              src_drop;
    logic              load_last;

    assign in_run    = (state == S_RUN);
    assign active    = in_run || (state == S_DRAIN);
    assign handshake = out_valid && AXIS_RNG.tready;
    // STOP wins over GO in the same idle cycle.
    assign go_start  = (state == S_IDLE) && RNG_GO && !RNG_STOP
                       && ((RNG_SEND_BYTES >> WORD_SHIFT) != '0);
    assign abort_req = active && RNG_STOP;

    assign fifo_flush = abort_req || (state == S_ABORT);
    assign fifo_pop   = !fifo_empty && (!out_valid || handshake) && !fifo_flush;
    assign fifo_push  = in_run && SRC_VALID && !abort_req && (!fifo_full || fifo_pop);
    assign src_drop   = in_run && SRC_VALID && !abort_req && fifo_full && !fifo_pop;

    // NOTE: default assignment first so always_comb cannot infer a latch.
    always_comb begin
        load_last = 1'b0;
        if (pkt_w != '0 && beat_cnt == pkt_w - CNT_W'(1)) load_last = 1'b1;
        if (word_idx == send_w - CNT_W'(1))               load_last = 1'b1;
    end

    rng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (SRC_DATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            send_w  <= '0;
            pkt_w   <= '0;
            acc_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_start) begin
                        state   <= S_RUN;
                        send_w  <= RNG_SEND_BYTES >> WORD_SHIFT;
                        pkt_w   <= RNG_DMA_BYTES >> WORD_SHIFT;
                        acc_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (RNG_STOP) begin
                        state <= S_ABORT;
                    end else if (fifo_push) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == send_w) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (RNG_STOP)                      state <= S_ABORT;
                    else if (fifo_empty && !out_valid) state <= S_IDLE;
                end
                S_ABORT: begin
                    if (!out_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single output register; last-flag is decided as each word is loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            word_idx  <= '0;
            beat_cnt  <= '0;
        end else begin
            if (go_start) begin
                word_idx <= '0;
                beat_cnt <= '0;
            end
            if (fifo_pop) begin
                out_valid <= 1'b1;
                out_data  <= fifo_rdata;
                out_last  <= load_last;
                word_idx  <= word_idx + CNT_W'(1);
                beat_cnt  <= load_last ? '0 : beat_cnt + CNT_W'(1);
            end else if (handshake) begin
                out_valid <= 1'b0;
            end else if (abort_req && out_valid) begin
                out_last  <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            over <= 1'b0;
            sent <= '0;
        end else if (go_start) begin
            over <= 1'b0;
            sent <= '0;
        end else begin
            if (src_drop)  over <= 1'b1;
            if (handshake) sent <= sent + CNT_W'(BYTES_PER_WORD);
        end
    end

`ifdef RNG_ONES_EN
    logic [31:0] stats;
    logic [32:0] stats_sum;

    assign stats_sum = {1'b0, stats} + 33'(popcount32(out_data));

    always_ff @(posedge CLK) begin
        if (RST || go_start) stats <= '0;
        else if (handshake)  stats <= stats_sum[32] ? '1 : stats_sum[31:0];
    end

    assign RNG_STATS = stats;
`else
    assign RNG_STATS = '0;
`endif

    assign RNG_RUN         = (state != S_IDLE);
    assign RNG_OVER        = over;
    assign RNG_SENT_BYTES  = sent;
    assign SRC_EN          = in_run;
    assign AXIS_RNG.tdata  = out_data;
    assign AXIS_RNG.tlast  = out_last;
    assign AXIS_RNG.tvalid = out_valid;

endmodule

// File: doc/rng_run_sequencer.md
Name: rng_run_sequencer

Overview:
Sequences one random-number run between the control-register block and the AXI-Stream output. On a GO pulse it enables the latch entropy sampler and collects raw 32-bit words into a small FIFO. It emits the words as AXIS packets of RNG_DMA_BYTES, stops the sampler once RNG_SEND_BYTES have been collected, and drains before returning to idle. It also reports run status, bytes sent and a sticky overrun flag back to the control registers.

Parameters:
FIFO_DEPTH, 16, word FIFO entries; power of 2, >=2
CNT_W, 32, width of byte counters and count inputs

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
RNG_GO  in  1  one-cycle start pulse
RNG_STOP  in  1  one-cycle abort pulse
RNG_SEND_BYTES  in  CNT_W  total bytes per run; bits[1:0] ignored
RNG_DMA_BYTES  in  CNT_W  bytes per AXIS packet; bits[1:0] ignored; 0 = single packet
RNG_RUN  out  1  high while not IDLE
RNG_OVER  out  1  sticky: a source word was dropped on a full FIFO
RNG_SENT_BYTES  out  CNT_W  bytes handshaken on AXIS this run
RNG_STATS  out  32  ones-count statistic (see Optional Feature)
SRC_EN  out  1  sampler enable
SRC_DATA  in  32  raw sampler word
SRC_VALID  in  1  word strobe; no backpressure possible
AXIS_RNG_TDATA  out  32  stream data
AXIS_RNG_TLAST  out  1  packet end
AXIS_RNG_TVALID  out  1  stream valid
AXIS_RNG_TREADY  in  1  stream ready

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; counters 0.
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Word counts are latched on GO: send_w = SEND_BYTES>>2, pkt_w = DMA_BYTES>>2.
- States: IDLE, RUN, DRAIN, ABORT.
- IDLE:
  - GO with send_w!=0 -> RUN.
  - On that transition: clear RNG_OVER, RNG_SENT_BYTES, the accepted-word counter, the packet-beat counter and the stats counter.
  - GO with send_w==0 is ignored.
- RUN:
  - SRC_EN=1.
  - On SRC_VALID with FIFO not full: push the word and increment the accepted count.
  - On SRC_VALID with FIFO full: drop the word and set RNG_OVER.
  - When the accepted count reaches send_w: SRC_EN=0 the next cycle -> DRAIN.
  - SRC_VALID arriving while SRC_EN=0 is ignored.
- DRAIN: when the FIFO is empty and the output register is empty -> IDLE.
- STOP in RUN or DRAIN -> ABORT:
  - SRC_EN=0 and the FIFO is flushed.
  - A beat already presented (TVALID=1) is held with TLAST forced 1 until the handshake.
  - -> IDLE once the output register is empty.
  - STOP in IDLE is ignored.
- GO outside IDLE is ignored. If GO and STOP occur in the same IDLE cycle, STOP wins (no run).
- Output stage:
  - Single register, loaded from the FIFO when empty or on a handshake (TVALID&TREADY).
  - Minimum latency SRC_VALID -> TVALID is 2 cycles.
  - TDATA and TLAST are stable while TVALID=1 and TREADY=0.
- TLAST=1 on:
  - the last beat of a packet (beat count == pkt_w-1, when pkt_w!=0), or
  - the final word of the run (word index send_w-1).
  - The packet-beat counter resets after every TLAST beat.
- RNG_SENT_BYTES += 4 per handshake, wrapping modulo 2^CNT_W.
- A FIFO push and pop in the same cycle while the FIFO is full is legal and drops nothing.

Optional Feature:
- Macro RNG_ONES_EN.
- Defined: RNG_STATS = saturating count of 1-bits across all handshaken TDATA words of the current run. It is cleared on a GO that starts a run and is updated the cycle after each handshake.
- Undefined: RNG_STATS is tied to 0 and the popcount logic is absent.

Decomposition:
- Package rng_seq_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/ABORT)
  - BYTES_PER_WORD=4
  - the word-width constant 32
  - a popcount function for 32-bit words
- Sub-module rng_word_fifo: synchronous FIFO, FIFO_DEPTH x 32, with full/empty flags and a synchronous flush input.

Test Plan:
- SEND=64, DMA=16, TREADY=1, SRC_VALID every cycle -> 16 beats, TLAST on beats 3,7,11,15, SENT_BYTES=64, RUN falls after the last beat, OVER=0.
- SEND=40, DMA=16 -> TLAST on beats 3,7,9 (short final packet), SENT_BYTES=40.
- FIFO_DEPTH=4, TREADY=0 for 10 cycles, SRC_VALID every cycle -> OVER=1 and stays 1 until the next GO; exactly 4 words + output register retained.
- STOP with TVALID=1, TREADY=0 -> TDATA held, TLAST=1; after TREADY=1, one handshake, FIFO flushed, RUN=0 within 2 cycles.
- GO with SEND=3 (send_w=0) -> RUN stays 0; GO during RUN -> no change to counters.
- RNG_ONES_EN defined, SRC_DATA=32'hFFFF_0000, SEND=8 -> RNG_STATS=32 after the run; undefined -> RNG_STATS=0.
